ir_queue_select: RTL

- Parametrised successor to the CPU's instruction-register select/encode logic.
- Adds a DEPTH-entry instruction prefetch buffer with a valid/ready handshake, and a registered instruction register (IR) loaded by the control unit.
- Decodes opcode, sign-extended constant and the select-and-encode register strobes for NUM_REGS registers, with priority and error detection on the Gra/Grb/Grc selects.
- Sits between the memory data path and the control unit / register file.

---
 rtl/ir_queue_select.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ir_queue_select.sv
// ---------------------------------------------------------------------------
// ir_queue_select
//
// Instruction-register select/encode block with a small prefetch buffer.
// Instruction words arrive from the memory data path over a valid/ready
// handshake and queue in a DEPTH-entry FIFO. The control unit pops the head
// into the instruction register (IR) with ir_load. The IR is decoded into
// opcode, a sign-extended constant, and one-hot register load/drive strobes
// chosen by the Gra/Grb/Grc field selects.
//
// Parameters
//   DATA_W  instruction width
//   OPC_W   opcode field width (the MSBs of the word)
//   REG_W   register field width; NUM_REGS = 2**REG_W
//   DEPTH   prefetch entries. Must be a power of 2 and at least 2, because
//           the pointers wrap by natural overflow.
//
// Instruction layout, MSB down: opcode | ra | rb | rc. The constant C is the
// low C_W = DATA_W-OPC_W-2*REG_W bits, so it overlaps rc.
//
// Ports
//   clk, clr            clock, synchronous active-high reset
//   flush               drop all buffered words. Beats push and ir_load.
//   in_valid/in_ready   push handshake for in_data
//   fifo_count          number of buffered words
//   ir_load             pop the head into ir_q. ir_valid pulses next cycle.
//   ir_q, ir_valid      IR contents and fresh-load pulse
//   opcode              opcode field
//   C_sign_extended     C field, sign-extended to DATA_W
//   Gra/Grb/Grc         field selects, priority Gra > Grb > Grc
//   Rin/Rout/BAout      register load / drive / base-address strobes
//   sel_index           selected register number (0 when nothing selected)
//   RegIn/RegOut        one-hot load / drive strobes
//   base_zero           BAout addressed R0: the bus must carry zero
//   sel_error           sticky flag, set when 2+ selects are high at an edge
//
// Build option
//   IR_DECODE_PIPE_EN   when defined, sel_index/RegIn/RegOut/base_zero are
//                       registered, giving one cycle of latency after the
//                       strobes. sel_error timing does not change.
// ---------------------------------------------------------------------------
module ir_queue_select #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int REG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  input  logic                         ir_load,
  output logic [DATA_W-1:0]            ir_q,
  output logic                         ir_valid,
  output logic [OPC_W-1:0]             opcode,
  output logic [DATA_W-1:0]            C_sign_extended,
  input  logic                         Gra,
  input  logic                         Grb,
  input  logic                         Grc,
  input  logic                         Rin,
  input  logic                         Rout,
  input  logic                         BAout,
  output logic [REG_W-1:0]             sel_index,
  output logic [(2**REG_W)-1:0]        RegIn,
  output logic [(2**REG_W)-1:0]        RegOut,
  output logic                         base_zero,
  output logic                         sel_error
);

  localparam int NUM_REGS = 2**REG_W;
  localparam int C_W      = DATA_W - OPC_W - 2*REG_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Bit positions of the register fields, counted down from the MSB.
  localparam int RA_MSB = DATA_W - OPC_W - 1;
  localparam int RB_MSB = RA_MSB - REG_W;
  localparam int RC_MSB = RB_MSB - REG_W;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic signed [DATA_W-1:0] sext_c(input logic [C_W-1:0] c);
    sext_c = {{(DATA_W-C_W){c[C_W-1]}}, c};
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic multi_select(input logic a, input logic b, input logic c);
    multi_select = (a & b) | (a & c) | (b & c);
  endfunction

  // -------------------------------------------------------------------------
  // Prefetch buffer state
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign in_ready   = !full && !clr;
  assign fifo_count = count;

  // in_ready is computed before the pop, so a full buffer never takes a word
  // in the same cycle it is popped. An empty-buffer load never bypasses
  // in_data: the word goes into the buffer instead.
  assign push = in_valid && in_ready && !flush;
  assign pop  = ir_load && !empty && !flush;

  // Storage is data only. Unwritten entries are never read because count
  // gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ir_q      <= '0;
      ir_valid  <= 1'b0;
      sel_error <= 1'b0;
    end else begin
      // The select-error monitor watches the strobes every edge, whatever
      // the buffer is doing.
      sel_error <= sel_error | multi_select(Gra, Grb, Grc);

      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        ir_valid <= 1'b0;
      end else begin
        ir_valid <= pop;
        if (pop) begin
          ir_q   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // p0: combinational decode from ir_q and the strobes
  // -------------------------------------------------------------------------
  logic [REG_W-1:0]          ra;
  logic [REG_W-1:0]          rb;
  logic [REG_W-1:0]          rc;
  logic signed [DATA_W-1:0]  c_sext;
  logic                      any_sel_p0;
  logic [REG_W-1:0]          sel_index_p0;
  logic [NUM_REGS-1:0]       reg_in_p0;
  logic [NUM_REGS-1:0]       reg_out_p0;
  logic                      base_zero_p0;

  assign opcode          = ir_q[DATA_W-1 -: OPC_W];
  assign ra              = ir_q[RA_MSB -: REG_W];
  assign rb              = ir_q[RB_MSB -: REG_W];
  assign rc              = ir_q[RC_MSB -: REG_W];
  assign c_sext          = sext_c(ir_q[C_W-1:0]);
  assign C_sign_extended = c_sext;

  always_comb begin
    any_sel_p0   = Gra | Grb | Grc;
    sel_index_p0 = '0;
    reg_in_p0    = '0;
    reg_out_p0   = '0;
    base_zero_p0 = 1'b0;

    if (Gra) begin
      sel_index_p0 = ra;
    end else if (Grb) begin
      sel_index_p0 = rb;
    end else if (Grc) begin
      sel_index_p0 = rc;
    end

    // With no select asserted, index 0 means "no register". It is not R0,
    // so none of the strobes fire.
    if (any_sel_p0) begin
      if (Rin) begin
        reg_in_p0 = onehot(sel_index_p0);
      end
      // A base address taken from R0 reads as literal zero. R0 is not
      // driven onto the bus.
      if (BAout && !Rout && (sel_index_p0 == '0)) begin
        base_zero_p0 = 1'b1;
      end else if (Rout || BAout) begin
        reg_out_p0 = onehot(sel_index_p0);
      end
    end
  end

`ifdef IR_DECODE_PIPE_EN
  // -------------------------------------------------------------------------
  // p1: registered select outputs
  // -------------------------------------------------------------------------
  logic [REG_W-1:0]    sel_index_p1;
  logic [NUM_REGS-1:0] reg_in_p1;
  logic [NUM_REGS-1:0] reg_out_p1;
  logic                base_zero_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      sel_index_p1 <= '0;
      reg_in_p1    <= '0;
      reg_out_p1   <= '0;
      base_zero_p1 <= 1'b0;
    end else begin
      sel_index_p1 <= sel_index_p0;
      reg_in_p1    <= reg_in_p0;
      reg_out_p1   <= reg_out_p0;
      base_zero_p1 <= base_zero_p0;
    end
  end

  assign sel_index = sel_index_p1;
  assign RegIn     = reg_in_p1;
  assign RegOut    = reg_out_p1;
  assign base_zero = base_zero_p1;
`else
  assign sel_index = sel_index_p0;
  assign RegIn     = reg_in_p0;
  assign RegOut    = reg_out_p0;
  assign base_zero = base_zero_p0;
`endif

endmodule
